axi_w_route_sequencer: RTL

Write-data channel scheduler for the AXI node master port. It buffers the port IDs granted by the write-address arbiter in order and steers W beats from exactly one slave port at a time to the master port. It releases each route on the `wlast` handshake, which keeps W-channel ordering identical to AW grant ordering. It sits between the AW arbitration stage (push side) and the outgoing W channel of one master port.

---
 rtl/axi_node_pkg.sv | 22 ++
 rtl/axi_w_id_fifo.sv | 50 +++++
 rtl/axi_w_route_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/axi_node_pkg.sv
// Shared types and helpers for the AXI node W-channel routing logic.
package axi_node_pkg;

    localparam int DEF_N_TARG_PORT = 7;
    localparam int DEF_LOG_N_TARG  = $clog2(DEF_N_TARG_PORT);

    // Queued AW grant: binary index in the upper bits, one-hot select below.
    typedef struct packed {
        logic [DEF_LOG_N_TARG-1:0]  bin;
        logic [DEF_N_TARG_PORT-1:0] oh;
    } id_entry_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } route_state_t;

    function automatic int id_width(input int n_targ);
        return $clog2(n_targ) + n_targ;
    endfunction

endpackage

// File: rtl/axi_w_id_fifo.sv
// Generic synchronous FIFO with async active-low reset; head is shown combinationally.
module axi_w_id_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/axi_w_route_sequencer.sv
// W-channel scheduler: routes W bursts from one slave port at a time in AW grant order,
// releasing each route on the wlast handshake.
module axi_w_route_sequencer
    import axi_node_pkg::*;
#(
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_USER_W  = 6,
    parameter int N_TARG_PORT = 7,
    parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 push_ID_i,
    input  logic [LOG_N_TARG+N_TARG_PORT-1:0]    ID_i,
    output logic                                 grant_FIFO_ID_o,
    input  logic [AXI_DATA_W-1:0]                wdata_i [N_TARG_PORT],
    input  logic [AXI_DATA_W/8-1:0]              wstrb_i [N_TARG_PORT],
    input  logic [N_TARG_PORT-1:0]               wlast_i,
    input  logic [AXI_USER_W-1:0]                wuser_i [N_TARG_PORT],
    input  logic [N_TARG_PORT-1:0]               wvalid_i,
    output logic [N_TARG_PORT-1:0]               wready_o,
    output logic [AXI_DATA_W-1:0]                wdata_o,
    output logic [AXI_DATA_W/8-1:0]              wstrb_o,
    output logic                                 wlast_o,
    output logic [AXI_USER_W-1:0]                wuser_o,
    output logic                                 wvalid_o,
    input  logic                                 wready_i,
    output logic [LOG_N_TARG-1:0]                active_port_o
);

    localparam int ID_W = id_width(N_TARG_PORT);

    logic                   r_active_q;
    logic [N_TARG_PORT-1:0] r_sel_oh_q;
    logic [LOG_N_TARG-1:0]  r_sel_bin_q;

    route_state_t           w_state;
    route_state_t           w_state_nxt;
    logic                   w_pop;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [ID_W-1:0]        w_head;
    logic                   w_last_hs;

    axi_w_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (FIFO_DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (push_ID_i),
        .i_pop   (w_pop),
        .i_data  (ID_i),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign grant_FIFO_ID_o = ~w_fifo_full;
    assign active_port_o   = r_sel_bin_q;
    assign w_state         = route_state_t'(r_active_q);
    assign w_last_hs       = wvalid_o & wready_i & wlast_o;

    // A finished burst hands over straight to the next queued grant with no idle cycle.
    always_comb begin
        w_state_nxt = w_state;
        w_pop       = 1'b0;
        case (w_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_last_hs) begin
                    if (!w_fifo_empty) w_pop = 1'b1;
                    else               w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_q  <= 1'b0;
            r_sel_oh_q  <= '0;
            r_sel_bin_q <= '0;
        end else begin
            r_active_q <= (w_state_nxt == ST_ACTIVE);
            if (w_pop) begin
                r_sel_oh_q  <= w_head[N_TARG_PORT-1:0];
                r_sel_bin_q <= w_head[ID_W-1 -: LOG_N_TARG];
            end
        end
    end

    always_comb begin
        wdata_o  = '0;
        wstrb_o  = '0;
        wlast_o  = 1'b0;
        wuser_o  = '0;
        wvalid_o = 1'b0;
        for (int i = 0; i < N_TARG_PORT; i++) begin
            if (r_active_q && r_sel_oh_q[i]) begin
                wdata_o  = wdata_o  | wdata_i[i];
                wstrb_o  = wstrb_o  | wstrb_i[i];
                wlast_o  = wlast_o  | wlast_i[i];
                wuser_o  = wuser_o  | wuser_i[i];
                wvalid_o = wvalid_o | wvalid_i[i];
            end
        end
    end

    assign wready_o = r_active_q ? (r_sel_oh_q & {N_TARG_PORT{wready_i}}) : '0;

    // The AW arbiter gates its handshake with grant, so a push into a full FIFO is a system bug.
    assert property (@(posedge clk) disable iff (!rst_n) !(push_ID_i && !grant_FIFO_ID_o));

endmodule
